// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: control-bit positions, the
// MEM/WB control bundle layout and the skid FSM state type.
package pipe_pkg;

  localparam int unsigned CTRL_REGWRITE  = 0;
  localparam int unsigned CTRL_MEMTOREG  = 1;
  localparam int unsigned CTRL_JAL       = 2;
  localparam int unsigned CTRL_LUI       = 3;
  localparam int unsigned CTRL_ALUSRC    = 4;
  localparam int unsigned CTRL_W_DEFAULT = 5;

  // Field order mirrors the bit positions above (regwrite is bit 0).
  typedef struct packed {
    logic alusrc;
    logic lui;
    logic jal;
    logic memtoreg;
    logic regwrite;
  } wb_ctrl_t;

  typedef enum logic {
    StEmptyOrOne,
    StFull
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// One-entry holding register with a valid flag; clear wins over unload and load.
module pipe_skid_slot #(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned CTRL_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              unload_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clear_i || unload_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush and optional skid slot.
// Define PIPE_STAGE_STATS_EN to add the saturating stall_cycles counter output.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned CTRL_W = CTRL_W_DEFAULT,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  skid_state_e       state_q, state_d;

  logic              skid_load, skid_unload, skid_clear;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic acc, drn;
  assign acc = in_valid & in_ready;
  assign drn = valid_q & out_ready;

  always_comb begin
    valid_d     = valid_q;
    ctrl_d      = ctrl_q;
    data_d      = data_q;
    state_d     = state_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;
    if (flush) begin
      valid_d    = 1'b0;
      ctrl_d     = '0;
      state_d    = StEmptyOrOne;
      skid_clear = 1'b1;
    end else if (skid_valid) begin
      // in_ready is low here, so no acc can race the promotion
      if (drn) begin
        valid_d     = 1'b1;
        ctrl_d      = skid_ctrl;
        data_d      = skid_data;
        skid_unload = 1'b1;
        state_d     = StEmptyOrOne;
      end
    end else if (acc && (!valid_q || drn)) begin
      valid_d = 1'b1;
      ctrl_d  = in_ctrl;
      data_d  = in_data;
    end else if (acc) begin
      skid_load = 1'b1;
      state_d   = StFull;
    end else if (drn) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      pipe_skid_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_slot (
        .clk      (clk),
        .reset    (reset),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .ctrl_i   (in_ctrl),
        .data_i   (in_data),
        .valid_o  (skid_valid),
        .ctrl_o   (skid_ctrl),
        .data_o   (skid_data)
      );

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_q <= StEmptyOrOne;
        end else begin
          state_q <= state_d;
        end
      end

      // Decoded straight from a flop: no path from out_ready.
      assign in_ready = (state_q == StEmptyOrOne);
    end else begin : g_plain
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
      assign state_q    = StEmptyOrOne;
      assign in_ready   = !valid_q | out_ready;
    end
  endgenerate

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

  assign out_valid = valid_q;
  assign out_ctrl  = ctrl_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one SKID=1 instance (a_*) and one SKID=0 instance (b_*).
module tb_pipe_stage_reg;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic          a_in_valid = 1'b0, a_in_ready, a_flush = 1'b0;
  logic          a_out_valid, a_out_ready = 1'b0;
  logic [CW-1:0] a_in_ctrl = '0, a_out_ctrl;
  logic [DW-1:0] a_in_data = '0, a_out_data;

  logic          b_in_valid = 1'b0, b_in_ready, b_flush = 1'b0;
  logic          b_out_valid, b_out_ready = 1'b0;
  logic [CW-1:0] b_in_ctrl = '0, b_out_ctrl;
  logic [DW-1:0] b_in_data = '0, b_out_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_dut_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_ctrl   (a_in_ctrl),
    .in_data   (a_in_data),
    .flush     (a_flush),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_ctrl  (a_out_ctrl),
    .out_data  (a_out_data)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_dut_plain (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_ctrl   (b_in_ctrl),
    .in_data   (b_in_data),
    .flush     (b_flush),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_ctrl  (b_out_ctrl),
    .out_data  (b_out_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [DW-1:0] d, input logic [CW-1:0] c);
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_ctrl  = c;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("a_rst_valid", 32'(a_out_valid), 32'd0);
    chk("a_rst_ctrl",  32'(a_out_ctrl),  32'd0);
    chk("a_rst_data",  32'(a_out_data),  32'd0);
    chk("a_rst_ready", 32'(a_in_ready),  32'd1);
    chk("b_rst_valid", 32'(b_out_valid), 32'd0);
    chk("b_rst_ready", 32'(b_in_ready),  32'd1);

    // SKID=1 streaming at full rate
    tick();
    a_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_send(DW'(i), CW'(i));
      tick();
      chk("a_stream_valid", 32'(a_out_valid), 32'd1);
      chk("a_stream_data",  32'(a_out_data),  32'(i));
      chk("a_stream_ctrl",  32'(a_out_ctrl),  32'(i));
      chk("a_stream_ready", 32'(a_in_ready),  32'd1);
    end
    a_in_valid = 1'b0;
    tick();
    chk("a_bubble_valid", 32'(a_out_valid), 32'd0);
    chk("a_bubble_ctrl",  32'(a_out_ctrl),  32'd0);
    chk("a_bubble_data",  32'(a_out_data),  32'd4);

    // Back-pressure fills the skid slot, then both drain in order
    a_out_ready = 1'b0;
    a_send(8'h0A, 5'h0A);
    tick();
    chk("a_A_data",  32'(a_out_data), 32'h0A);
    chk("a_A_ready", 32'(a_in_ready), 32'd1);
    a_send(8'h0B, 5'h0B);
    tick();
    chk("a_skid_ready", 32'(a_in_ready), 32'd0);
    chk("a_skid_hold",  32'(a_out_data), 32'h0A);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tick();
    chk("a_B_valid", 32'(a_out_valid), 32'd1);
    chk("a_B_data",  32'(a_out_data),  32'h0B);
    chk("a_B_ctrl",  32'(a_out_ctrl),  32'h0B);
    chk("a_B_ready", 32'(a_in_ready),  32'd1);
    tick();
    chk("a_drain_valid", 32'(a_out_valid), 32'd0);

    // Flush with skid full and item C offered
    a_out_ready = 1'b0;
    a_send(8'h0D, 5'h0D);
    tick();
    a_send(8'h0E, 5'h0E);
    tick();
    chk("a_full_ready", 32'(a_in_ready), 32'd0);
    a_send(8'h0C, 5'h0C);
    a_flush = 1'b1;
    tick();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    chk("a_flush_valid", 32'(a_out_valid), 32'd0);
    chk("a_flush_ctrl",  32'(a_out_ctrl),  32'd0);
    chk("a_flush_ready", 32'(a_in_ready),  32'd1);
    chk("a_flush_data",  32'(a_out_data),  32'h0D);
    a_out_ready = 1'b1;
    tick();
    chk("a_flush_noC", 32'(a_out_valid), 32'd0);

    // Flush beats a simultaneous accept
    a_send(8'h0F, 5'h0F);
    a_flush = 1'b1;
    tick();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    chk("a_flush_acc_valid", 32'(a_out_valid), 32'd0);
    tick();
    chk("a_flush_acc_drop", 32'(a_out_valid), 32'd0);

    // Asynchronous reset mid-stream with skid full
    a_out_ready = 1'b0;
    a_send(8'h11, 5'h11);
    tick();
    a_send(8'h12, 5'h12);
    tick();
    a_in_valid = 1'b0;
    chk("a_pre_rst_ready", 32'(a_in_ready), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("a_arst_valid", 32'(a_out_valid), 32'd0);
    chk("a_arst_ctrl",  32'(a_out_ctrl),  32'd0);
    chk("a_arst_data",  32'(a_out_data),  32'd0);
    chk("a_arst_ready", 32'(a_in_ready),  32'd1);
    tick();
    reset = 1'b0;
    a_out_ready = 1'b1;
    tick();
    chk("a_arst_skid_gone", 32'(a_out_valid), 32'd0);

    // SKID=0: combinational in_ready
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_data   = 8'h21;
    b_in_ctrl   = 5'h01;
    tick();
    b_in_data = 8'h33;
    b_in_ctrl = 5'h03;
    #1;
    chk("b_load_data",  32'(b_out_data), 32'h21);
    chk("b_stall_ready", 32'(b_in_ready), 32'd0);
    tick();
    chk("b_stall_hold", 32'(b_out_data), 32'h21);
    b_out_ready = 1'b1;
    #1;
    chk("b_comb_ready", 32'(b_in_ready), 32'd1);
    b_in_data = 8'h22;
    b_in_ctrl = 5'h02;
    tick();
    chk("b_reload_data",  32'(b_out_data),  32'h22);
    chk("b_reload_ctrl",  32'(b_out_ctrl),  32'h02);
    chk("b_reload_valid", 32'(b_out_valid), 32'd1);
    b_in_valid = 1'b0;
    tick();
    chk("b_bubble_valid", 32'(b_out_valid), 32'd0);
    chk("b_bubble_ctrl",  32'(b_out_ctrl),  32'd0);
    chk("b_bubble_data",  32'(b_out_data),  32'h22);

    // SKID=0 flush over a simultaneous accept while an item is held
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_data   = 8'h44;
    b_in_ctrl   = 5'h04;
    tick();
    b_in_data = 8'h55;
    b_in_ctrl = 5'h05;
    b_out_ready = 1'b1;
    b_flush = 1'b1;
    tick();
    b_flush    = 1'b0;
    b_in_valid = 1'b0;
    chk("b_flush_valid", 32'(b_out_valid), 32'd0);
    chk("b_flush_ctrl",  32'(b_out_ctrl),  32'd0);
    chk("b_flush_ready", 32'(b_in_ready),  32'd1);
    chk("b_flush_data",  32'(b_out_data),  32'h44);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
